// File: rtl/axi4_lite_read_slave.sv
// AXI4-Lite read-only slave bridging AR/R channels to a simple word-addressed
// memory port, with address decode, bounded memory wait and SLVERR responses.
module axi4_lite_read_slave #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1000_0000,
  parameter int                    NUM_WORDS      = 16,
  parameter int                    TIMEOUT_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic                         mem_req,
  output logic [$clog2(NUM_WORDS)-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  input  logic                         mem_rvalid
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_WAIT,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [IDX_W-1:0]      mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  // Address decode works on word offsets so every bit of the difference is used.
  logic [ADDR_WIDTH-3:0] word_off;
  logic                  above_base;
  logic                  in_window;
  logic                  misaligned;
  logic                  decode_err;

  assign word_off   = S_AXI_ARADDR[ADDR_WIDTH-1:2] - BASE_ADDR[ADDR_WIDTH-1:2];
  assign above_base = (S_AXI_ARADDR >= BASE_ADDR);
  assign in_window  = (word_off[ADDR_WIDTH-3:IDX_W] == '0);
  assign misaligned = |S_AXI_ARADDR[1:0];
  assign decode_err = misaligned || !above_base || !in_window;

  // Gated by rst_n so ARREADY is low during reset and high the moment it releases.
  assign S_AXI_ARREADY = rst_n && (state_q == S_IDLE);
  assign S_AXI_RVALID  = (state_q == S_RESP);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_d    = state_q;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;

    unique case (state_q)
      S_IDLE: begin
        if (S_AXI_ARVALID && S_AXI_ARREADY) begin
          if (decode_err) begin
            state_d = S_RESP;
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            state_d    = S_MEM_WAIT;
            mem_req_d  = 1'b1;
            mem_addr_d = word_off[IDX_W-1:0];
            cnt_d      = '0;
          end
        end
      end

      S_MEM_WAIT: begin
        // Data arriving on the last allowed cycle still wins over the timeout.
        if (mem_rvalid) begin
          state_d = S_RESP;
          rdata_d = mem_rdata;
          rresp_d = RESP_OKAY;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        if (S_AXI_RREADY) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: doc/axi4_lite_read_slave.md
AXI4_LITE_READ_SLAVE -- requirements
Module: axi4_lite_read_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI and memory data width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h1000_0000, byte address of word 0.
REQ-004 SHALL have parameter NUM_WORDS, default 16, number of decoded words (power of 2, at least 2).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 8, maximum memory wait in cycles (at least 2).
REQ-006 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port S_AXI_ARADDR, input, ADDR_WIDTH, read address.
REQ-009 SHALL have port S_AXI_ARVALID, input, 1, address valid.
REQ-010 SHALL have port S_AXI_ARREADY, output, 1, slave accepts address.
REQ-011 SHALL have port S_AXI_RDATA, output, DATA_WIDTH, read data.
REQ-012 SHALL have port S_AXI_RRESP, output, 2, 2'b00 OKAY or 2'b10 SLVERR.
REQ-013 SHALL have port S_AXI_RVALID, output, 1, read data valid.
REQ-014 SHALL have port S_AXI_RREADY, input, 1, master accepts data.
REQ-015 SHALL have port mem_req, output, 1, one-cycle memory read request.
REQ-016 SHALL have port mem_addr, output, $clog2(NUM_WORDS), word index.
REQ-017 SHALL have port mem_rdata, input, DATA_WIDTH, memory read data.
REQ-018 SHALL have port mem_rvalid, input, 1, mem_rdata valid.

Function
REQ-019 SHALL implement states IDLE, MEM_WAIT and RESP.
REQ-020 SHALL drive S_AXI_ARREADY=1 only in IDLE; an AR handshake is ARVALID&ARREADY at a rising edge.
REQ-021 SHALL register S_AXI_ARADDR at the handshake.
REQ-022 SHALL flag a decode error when ARADDR[1:0]!=0 or ARADDR is outside [BASE_ADDR, BASE_ADDR+4*NUM_WORDS-1].
REQ-023 SHALL, on a handshake with no decode error, enter MEM_WAIT with mem_addr=(ARADDR-BASE_ADDR)>>2, held constant until MEM_WAIT exits.
REQ-024 SHALL assert mem_req for exactly the first cycle spent in MEM_WAIT.
REQ-025 SHALL, on a handshake with a decode error, enter RESP directly with RDATA=0 and RRESP=2'b10, never asserting mem_req.
REQ-026 SHALL accept mem_rvalid in MEM_WAIT from the mem_req cycle onward, capture mem_rdata with RRESP=2'b00 and enter RESP.
REQ-027 SHALL count MEM_WAIT cycles; with mem_rvalid never high, enter RESP with RDATA=0 and RRESP=2'b10 after exactly TIMEOUT_CYCLES cycles in MEM_WAIT.
REQ-028 SHALL give mem_rvalid priority over timeout when both occur in the same cycle (OKAY response).
REQ-029 SHALL ignore mem_rvalid outside MEM_WAIT.
REQ-030 SHALL hold S_AXI_RVALID=1 with RDATA and RRESP stable throughout RESP until RVALID&RREADY, then return to IDLE.
REQ-031 SHALL give a latency of handshake-edge to RVALID-high of 1 cycle for a decode error, and 1 cycle plus memory latency for a hit (mem_rvalid at the mem_req cycle gives RVALID 2 cycles after the handshake).
REQ-032 SHALL insert exactly one IDLE cycle between transactions (ARREADY high the cycle after the R handshake).

Reset
REQ-033 SHALL, while rst_n=0, force IDLE with S_AXI_ARREADY=0, S_AXI_RVALID=0, S_AXI_RDATA=0, S_AXI_RRESP=0, mem_req=0, mem_addr=0, timeout counter=0.
REQ-034 SHALL, on reset mid-transaction, drop RVALID immediately and discard any later mem_rvalid.
REQ-035 SHALL assert ARREADY in the first cycle after rst_n deasserts.

Verification
REQ-036 SHALL cover a hit: ARADDR=0x1000_0008, mem_rvalid 3 cycles after mem_req with 0xDEADBEEF -> mem_addr=2, RDATA=0xDEADBEEF, RRESP=00.
REQ-037 SHALL cover decode errors: ARADDR=0x1000_0040 and 0x1000_0005 -> no mem_req, RVALID 1 cycle after handshake, RRESP=10, RDATA=0.
REQ-038 SHALL cover timeout: hit to 0x1000_0000 with mem_rvalid never asserted -> RVALID with RRESP=10 after 8 MEM_WAIT cycles; a later stray mem_rvalid is ignored.
REQ-039 SHALL cover backpressure: RREADY held low 5 cycles -> RVALID/RDATA/RRESP stable, ARREADY=0 throughout, ARREADY=1 one cycle after RREADY rises.
REQ-040 SHALL cover a tie: mem_rvalid in the 8th MEM_WAIT cycle -> RRESP=00 with captured data.
REQ-041 SHALL cover reset in MEM_WAIT and in RESP -> all outputs zero immediately, ARREADY=1 first cycle after release.
